flit_injector: RTL and testbench
================================

# flit_injector

Local-port injection engine for a node: accepts packet requests from the processing element, assigns packet IDs, and serializes each packet into flits whose SRC, DST, PKT_ID and FLIT_NUM fields are filled in. The injector is the source of every header field that route computation later decodes. Flits enter the router's local input slot only in cycles the router reports that slot as free, because the bufferless router cannot back-pressure an occupied slot.

## Interface
- REQ_DEPTH, 4: request FIFO entries (power of two, ≥2).
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- CURRENT_POSITION  in  `COORDINATE_SIZE`  this node's {X[2:0],Y[2:0]}, static after reset.
- req_valid  in  1  packet request offered.
- req_ready  out  1  FIFO not full; request accepted when req_valid & req_ready at clock edge.
- req_dest  in  `COORDINATE_SIZE`  destination coordinate.
- req_len  in  `FLITNUM_SIZE`  flit count, 1..2^`FLITNUM_SIZE`-1.
- payload  in  `CHANNEL_SIZE`  next flit body; header field positions ignored.
- pl_ready  out  1  payload consumed this cycle (combinational).
- inj_slot_free  in  1  local input slot empty next cycle.
- inj_flit  out  `CHANNEL_SIZE`  registered flit to local input port; all-zero = no flit.
- req_err  out  1  one-cycle pulse: request dropped.

## Operation
- Request FIFO holds {dest,len}; full when REQ_DEPTH entries, req_ready = ~full.
- Drop at the FIFO input, no enqueue, req_err=1 next cycle:
  - req_len==0.
  - req_dest==CURRENT_POSITION. This guarantees a src≠dest flit, and therefore every emitted flit is non-zero.
- FSM states:
  - IDLE: FIFO non-empty → pop head into hdr_dest/hdr_len, flit_cnt=0, go SEND.
  - SEND: emit = inj_slot_free. On emit:
    - inj_flit ← payload with SRC=CURRENT_POSITION, DST=hdr_dest, PKT_ID=pkt_id, FLIT_NUM=flit_cnt.
    - flit_cnt++.
  - SEND, last flit (flit_cnt==hdr_len-1) emitted:
    - pkt_id++ (wraps modulo 2^`PKTID_SIZE`).
    - FIFO non-empty → pop next and stay in SEND (back-to-back packets).
    - Otherwise → IDLE.
- pl_ready = (state==SEND) & inj_slot_free.
- When not emitting, inj_flit ← 0 at the next edge.
- Flits of one packet leave in FLIT_NUM order. Packets leave in request order; no interleaving.
- Simultaneous enqueue and dequeue when full: req_ready is already 0, so no enqueue occurs. When empty, a same-cycle push is not visible to the pop; it is popped next cycle.

## Timing
- Reset values: inj_flit=0, req_ready=1, pl_ready=0, req_err=0, state=IDLE, pkt_id=0, FIFO empty.
- Reset mid-packet: the partial packet is abandoned and inj_flit clears immediately (asynchronous).
- Request-to-first-flit latency with slot free: accept at edge t, pop at t+1, flit visible after edge t+2.
- inj_slot_free sampled at edge t → flit on inj_flit from t until t+1.
- Throughput: 1 flit/cycle while slot free; no bubble between packets.
- Stall: inj_slot_free=0 holds flit_cnt and header; pl_ready=0.

## Configuration
- INJ_STATS_EN defined: adds two output ports, reset to 0, both saturating at 16'hFFFF (no wrap):
  - inj_pkt_count out 16: +1 per last flit emitted.
  - inj_stall_count out 16: +1 per SEND cycle with inj_slot_free=0.
- INJ_STATS_EN undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Position 6'o23, request dest 6'o57 len 3, slot always free:
  - Three consecutive flits with FLIT_NUM 0,1,2, PKT_ID 0, SRC 6'o23, DST 6'o57.
  - First flit appears two cycles after accept.
- Two len-2 requests back-to-back:
  - Four consecutive flits with no gap; PKT_IDs 0,0,1,1.
- slot_free pattern 1,0,0,1 during a len-2 packet:
  - Flits only after the cycles with slot_free=1; inj_flit=0 otherwise; pl_ready low during stalls.
  - With INJ_STATS_EN: stall_count=2.
- Fill FIFO with REQ_DEPTH requests while slot_free=0:
  - req_ready drops after REQ_DEPTH+1 accepts (one request is held in the header registers).
  - Request dest==CURRENT_POSITION → req_err pulse, no flit ever emitted.
- 2^`PKTID_SIZE`+1 single-flit packets:
  - PKT_ID wraps from max to 0.
  - Assert rst_n=0 mid-packet → inj_flit 0 immediately; after release, next packet has PKT_ID 0.

Source files
------------

// File: rtl/flit_injector.sv
// flit_injector -- local-port injection engine.
//
// Accepts packet requests {dest,len} from the processing element into a
// small FIFO, assigns packet IDs and serializes each packet into flits
// carrying SRC, DST, PKT_ID and FLIT_NUM. A flit is only launched in a cycle
// the router reports its local input slot as free.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   CURRENT_POSITION   this node's {X,Y}, static after reset
//   req_valid/ready    request handshake; req_dest, req_len describe packet
//   payload/pl_ready   next flit body / body consumed this cycle
//   inj_slot_free      local input slot empty next cycle
//   inj_flit           registered flit to the router, all-zero = no flit
//   req_err            one-cycle pulse when a request is dropped
//   inj_pkt_count,
//   inj_stall_count    saturating statistics (only with INJ_STATS_EN)
//
// Optional feature macro: INJ_STATS_EN.
//
// Flit layout (LSB first): DST | SRC | PKT_ID | FLIT_NUM | body.

`ifndef COORDINATE_SIZE
`define COORDINATE_SIZE 6
`endif
`ifndef FLITNUM_SIZE
`define FLITNUM_SIZE 3
`endif
`ifndef PKTID_SIZE
`define PKTID_SIZE 4
`endif
`ifndef CHANNEL_SIZE
`define CHANNEL_SIZE 32
`endif

module flit_injector #(
    parameter int REQ_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [`COORDINATE_SIZE-1:0]  CURRENT_POSITION,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [`COORDINATE_SIZE-1:0]  req_dest,
    input  logic [`FLITNUM_SIZE-1:0]     req_len,
    input  logic [`CHANNEL_SIZE-1:0]     payload,
    output logic                         pl_ready,
    input  logic                         inj_slot_free,
    output logic [`CHANNEL_SIZE-1:0]     inj_flit,
`ifdef INJ_STATS_EN
    output logic [15:0]                  inj_pkt_count,
    output logic [15:0]                  inj_stall_count,
`endif
    output logic                         req_err
);

    localparam int CW       = `COORDINATE_SIZE;
    localparam int FW       = `FLITNUM_SIZE;
    localparam int PW       = `PKTID_SIZE;
    localparam int DST_LSB  = 0;
    localparam int SRC_LSB  = CW;
    localparam int PID_LSB  = 2 * CW;
    localparam int FNUM_LSB = 2 * CW + PW;
    localparam int PTR_W    = $clog2(REQ_DEPTH);

    typedef struct packed {
        logic [CW-1:0] dest;
        logic [FW-1:0] len;
    } reqEntry_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // ---------------- request FIFO ----------------
    reqEntry_t        fifoMem [REQ_DEPTH];
    logic [PTR_W:0]   wrPtr, rdPtr;
    logic             fifoEmpty, fifoFull;
    logic             reqAccept, reqBad, push, pop;
    reqEntry_t        headEntry;

    assign fifoEmpty = (wrPtr == rdPtr);
    assign fifoFull  = (wrPtr[PTR_W] != rdPtr[PTR_W]) &&
                       (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);
    assign req_ready = ~fifoFull;
    assign reqAccept = req_valid & req_ready;
    // A zero-length packet or one addressed to ourselves is never enqueued;
    // the second rule also guarantees every emitted flit is non-zero.
    assign reqBad    = (req_len == '0) || (req_dest == CURRENT_POSITION);
    assign push      = reqAccept & ~reqBad;
    assign headEntry = fifoMem[rdPtr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem[wrPtr[PTR_W-1:0]] <= '{dest: req_dest, len: req_len};
        end
    end

    // ---------------- packet sequencer ----------------
    state_t           state, stateNext;
    logic [CW-1:0]    hdrDest;
    logic [FW-1:0]    hdrLen, flitCnt, lastIdx;
    logic [PW-1:0]    pktId;
    logic             emit, lastFlit;
    logic [`CHANNEL_SIZE-1:0] flitOut;

    assign lastIdx  = hdrLen - 1'b1;
    assign pl_ready = emit;

    always_comb begin
        stateNext = state;
        pop       = 1'b0;
        emit      = 1'b0;
        lastFlit  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifoEmpty) begin
                    pop       = 1'b1;
                    stateNext = SEND;
                end
            end
            SEND: begin
                emit     = inj_slot_free;
                lastFlit = (flitCnt == lastIdx);
                // Chain straight into the next packet to avoid a bubble.
                if (emit && lastFlit) begin
                    if (!fifoEmpty) pop = 1'b1;
                    else            stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        flitOut = payload;
        flitOut[DST_LSB  +: CW] = hdrDest;
        flitOut[SRC_LSB  +: CW] = CURRENT_POSITION;
        flitOut[PID_LSB  +: PW] = pktId;
        flitOut[FNUM_LSB +: FW] = flitCnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wrPtr    <= '0;
            rdPtr    <= '0;
            hdrDest  <= '0;
            hdrLen   <= '0;
            flitCnt  <= '0;
            pktId    <= '0;
            inj_flit <= '0;
            req_err  <= 1'b0;
        end else begin
            state   <= stateNext;
            req_err <= reqAccept & reqBad;
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop) begin
                rdPtr   <= rdPtr + 1'b1;
                hdrDest <= headEntry.dest;
                hdrLen  <= headEntry.len;
                flitCnt <= '0;
            end else if (emit) begin
                flitCnt <= flitCnt + 1'b1;
            end
            if (emit && lastFlit) pktId <= pktId + 1'b1;
            inj_flit <= emit ? flitOut : '0;
        end
    end

`ifdef INJ_STATS_EN
    // ---------------- statistics (saturating) ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_pkt_count   <= '0;
            inj_stall_count <= '0;
        end else begin
            if (emit && lastFlit && (inj_pkt_count != 16'hFFFF))
                inj_pkt_count <= inj_pkt_count + 1'b1;
            if ((state == SEND) && !inj_slot_free && (inj_stall_count != 16'hFFFF))
                inj_stall_count <= inj_stall_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_flit_injector.sv
// Testbench for flit_injector: a queue-based packet model predicts the flit
// stream (header fields and consumed payload bodies in order), checked every
// cycle, plus directed literal checks on latency, gaps, stalls, FIFO depth,
// drops, PKT_ID wrap and asynchronous reset.

`ifndef COORDINATE_SIZE
`define COORDINATE_SIZE 6
`endif
`ifndef FLITNUM_SIZE
`define FLITNUM_SIZE 3
`endif
`ifndef PKTID_SIZE
`define PKTID_SIZE 4
`endif
`ifndef CHANNEL_SIZE
`define CHANNEL_SIZE 32
`endif

module tb_flit_injector;

    localparam logic [5:0] POS = 6'o23;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_dest = 6'o00;
    logic [2:0]  req_len = 3'd0;
    logic [31:0] payload;
    logic        pl_ready;
    logic        inj_slot_free = 1'b0;
    logic [31:0] inj_flit;
    logic        req_err;
`ifdef INJ_STATS_EN
    logic [15:0] inj_pkt_count, inj_stall_count;
`endif

    always #5 clk = ~clk;

    flit_injector #(.REQ_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .CURRENT_POSITION(POS),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dest(req_dest), .req_len(req_len),
        .payload(payload), .pl_ready(pl_ready),
        .inj_slot_free(inj_slot_free), .inj_flit(inj_flit),
`ifdef INJ_STATS_EN
        .inj_pkt_count(inj_pkt_count), .inj_stall_count(inj_stall_count),
`endif
        .req_err(req_err)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Body of the k-th flit the PE hands over; header bits deliberately dirty.
    function automatic logic [31:0] bodyGen(input int k);
        return 32'hDEADBEEF ^ (32'(k) * 32'h9E3779B9);
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [5:0] dst;
        logic [3:0] pid;
        logic [2:0] fnum;
    } expFlit_t;

    expFlit_t    expQ[$];
    logic [3:0]  mPid;
    logic        expErr;
    logic        prevSlot;
    int          bodyIdx;
    int          emitCnt;
    logic [31:0] hist [0:63];

    assign payload = bodyGen(bodyIdx);

    // Every accepted good request contributes len flits, PKT_ID = accepted
    // packet count since reset modulo 16.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            expQ.delete();
            mPid     = 4'd0;
            expErr   = 1'b0;
            prevSlot = 1'b0;
            bodyIdx <= 0;
        end else begin
            prevSlot = inj_slot_free;
            expErr   = 1'b0;
            if (req_valid && req_ready) begin
                if (req_len == 3'd0 || req_dest == POS) expErr = 1'b1;
                else begin
                    for (int i = 0; i < int'(req_len); i++)
                        expQ.push_back('{dst: req_dest, pid: mPid, fnum: 3'(i)});
                    mPid = mPid + 4'd1;
                end
            end
            bodyIdx <= bodyIdx + (pl_ready ? 1 : 0);
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk or negedge rst_n);
        if (!rst_n) emitCnt = 0;
        else if (!clk) begin
            if (inj_flit != 32'd0) begin
                expFlit_t    e;
                logic [31:0] b;
                chk("flit_without_free_slot", {31'd0, prevSlot}, 32'd1);
                if (expQ.size() == 0) begin
                    chk("spurious_flit", inj_flit, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    b = bodyGen(emitCnt);
                    chk("flit_stream", inj_flit, {b[31:19], e.fnum, e.pid, POS, e.dst});
                end
                hist[emitCnt % 64] = inj_flit;
                emitCnt++;
            end
            chk("req_err", {31'd0, req_err}, {31'd0, expErr});
        end
    end

    // ---------------- helpers ----------------
    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 1'b0;
        inj_slot_free = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic drain(input string nm, input int bound);
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (expQ.size() == 0) break;
        end
        chk(nm, expQ.size(), 32'd0);
    endtask

    task automatic waitFlit(input string nm, input int bound);
        logic found = 1'b0;
        for (int c = 0; c < bound && !found; c++) begin
            @(negedge clk);
            found = (inj_flit != 32'd0);
        end
        chk(nm, {31'd0, found}, 32'd1);
    endtask

    task automatic pushReq(input logic [5:0] d, input logic [2:0] l);
        logic acc = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_dest = d; req_len = l;
        for (int c = 0; c < 20 && !acc; c++) begin
            @(posedge clk);
            acc = req_ready;
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("push_accepted", {31'd0, acc}, 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int accepts;

        doReset();
        @(negedge clk);
        chk("rst_inj_flit", inj_flit, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_pl_ready", {31'd0, pl_ready}, 32'd0);
        chk("rst_req_err", {31'd0, req_err}, 32'd0);
`ifdef INJ_STATS_EN
        chk("rst_pkt_count", {16'd0, inj_pkt_count}, 32'd0);
        chk("rst_stall_count", {16'd0, inj_stall_count}, 32'd0);
`endif

        // 1: dest 6'o57 len 3, slot free; first flit two cycles after accept
        inj_slot_free = 1'b1;
        req_valid = 1'b1; req_dest = 6'o57; req_len = 3'd3;
        @(negedge clk); req_valid = 1'b0;
        chk("t1_lat0", inj_flit, 32'd0);
        @(negedge clk); chk("t1_lat1", inj_flit, 32'd0);
        @(negedge clk); chk("t1_f0", {13'd0, inj_flit[18:0]}, 32'h004EF);
        @(negedge clk); chk("t1_f1", {13'd0, inj_flit[18:0]}, 32'h104EF);
        @(negedge clk); chk("t1_f2", {13'd0, inj_flit[18:0]}, 32'h204EF);
        @(negedge clk); chk("t1_end", inj_flit, 32'd0);

        // 2: two len-2 packets back to back, no gap
        doReset();
        @(negedge clk);
        inj_slot_free = 1'b1;
        req_valid = 1'b1; req_dest = 6'o01; req_len = 3'd2;
        @(negedge clk);
        @(negedge clk); req_valid = 1'b0;
        chk("t2_lat", inj_flit, 32'd0);
        @(negedge clk); chk("t2_f0", {13'd0, inj_flit[18:0]}, 32'h004C1);
        @(negedge clk); chk("t2_f1", {13'd0, inj_flit[18:0]}, 32'h104C1);
        @(negedge clk); chk("t2_f2", {13'd0, inj_flit[18:0]}, 32'h014C1);
        @(negedge clk); chk("t2_f3", {13'd0, inj_flit[18:0]}, 32'h114C1);
        @(negedge clk); chk("t2_end", inj_flit, 32'd0);

        // 3: slot_free 1,0,0,1 during a len-2 packet
        doReset();
        @(negedge clk);
        req_valid = 1'b1; req_dest = 6'o01; req_len = 3'd2;
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk); inj_slot_free = 1'b1;
        #1 chk("t3_plr_c0", {31'd0, pl_ready}, 32'd1);
        @(negedge clk); chk("t3_f0", {13'd0, inj_flit[18:0]}, 32'h004C1);
        inj_slot_free = 1'b0;
        #1 chk("t3_plr_c1", {31'd0, pl_ready}, 32'd0);
        @(negedge clk); chk("t3_gap1", inj_flit, 32'd0);
        #1 chk("t3_plr_c2", {31'd0, pl_ready}, 32'd0);
        @(negedge clk); chk("t3_gap2", inj_flit, 32'd0);
        inj_slot_free = 1'b1;
        #1 chk("t3_plr_c3", {31'd0, pl_ready}, 32'd1);
        @(negedge clk); chk("t3_f1", {13'd0, inj_flit[18:0]}, 32'h104C1);
        #1 chk("t3_plr_idle", {31'd0, pl_ready}, 32'd0);
`ifdef INJ_STATS_EN
        chk("t3_stall_count", {16'd0, inj_stall_count}, 32'd2);
        chk("t3_pkt_count", {16'd0, inj_pkt_count}, 32'd1);
`endif

        // 4: fill the FIFO with the slot blocked
        doReset();
        @(negedge clk);
        inj_slot_free = 1'b0;
        req_valid = 1'b1; req_len = 3'd1;
        accepts = 0;
        for (int c = 0; c < 10; c++) begin
            req_dest = 6'(6'o40 + c);
            @(posedge clk);
            if (req_ready) accepts++;
            @(negedge clk);
            if (!req_ready) break;
        end
        req_valid = 1'b0;
        chk("t4_accepts", accepts, 32'd5);
        chk("t4_full", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("t4_still_full", {31'd0, req_ready}, 32'd0);
        inj_slot_free = 1'b1;
        drain("t4_drain", 30);
        @(negedge clk);
        chk("t4_ready_again", {31'd0, req_ready}, 32'd1);

        // dropped requests: dest == own position, and len == 0
        req_valid = 1'b1; req_dest = POS; req_len = 3'd2;
        @(negedge clk); req_valid = 1'b0;
        chk("t4_err_self", {31'd0, req_err}, 32'd1);
        @(negedge clk); chk("t4_err_clear", {31'd0, req_err}, 32'd0);
        req_valid = 1'b1; req_dest = 6'o01; req_len = 3'd0;
        @(negedge clk); req_valid = 1'b0;
        chk("t4_err_len0", {31'd0, req_err}, 32'd1);
        for (int c = 0; c < 5; c++) @(negedge clk);
        chk("t4_no_flit", inj_flit, 32'd0);
        chk("t4_idle_plr", {31'd0, pl_ready}, 32'd0);
        chk("t4_no_pending", expQ.size(), 32'd0);

        // 5: 17 single-flit packets, PKT_ID wraps 15 -> 0
        doReset();
        inj_slot_free = 1'b1;
        for (int k = 0; k < 17; k++) pushReq(6'o01, 3'd1);
        drain("t5_drain", 30);
        chk("t5_pid0", {28'd0, hist[0][15:12]}, 32'd0);
        chk("t5_pid15", {28'd0, hist[15][15:12]}, 32'd15);
        chk("t5_pid_wrap", {28'd0, hist[16][15:12]}, 32'd0);

        // asynchronous reset mid-packet
        pushReq(6'o01, 3'd5);
        waitFlit("t5_midpkt_start", 10);
        #2 rst_n = 1'b0;
        #1 chk("t5_async_clear", inj_flit, 32'd0);
        chk("t5_async_plr", {31'd0, pl_ready}, 32'd0);
        chk("t5_async_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        inj_slot_free = 1'b1;
        pushReq(6'o01, 3'd1);
        waitFlit("t5_post_rst_flit", 10);
        chk("t5_post_rst_pid", {28'd0, inj_flit[15:12]}, 32'd0);
        chk("t5_post_rst_fnum", {29'd0, inj_flit[18:16]}, 32'd0);
        drain("t5_final_drain", 10);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
